// File: rtl/regfile_pkg.sv
// Shared defaults and address-width helper for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 32;
    localparam int unsigned DEF_NREAD = 2;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero/range/bypass data mux and busy qualification.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AW       = addr_width(DEF_DEPTH),
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] stored,
    input  logic             stored_busy,
    input  logic             we3,
    input  logic [AW-1:0]    a3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             we4,
    input  logic [AW-1:0]    a4,
    input  logic [WIDTH-1:0] wd4,
    input  logic             setbusy,
    input  logic [AW-1:0]    abusy,
    output logic [WIDTH-1:0] rd,
    output logic             busy
);

    logic is_zero;
    logic in_range;
    logic hit3;
    logic hit4;
    logic reissue;

    assign is_zero  = (ZERO_REG != 0) && (addr == '0);
    assign in_range = 32'(addr) < DEPTH;
    assign hit4     = (BYPASS != 0) && we4 && (a4 == addr);
    assign hit3     = (BYPASS != 0) && we3 && (a3 == addr);
    assign reissue  = setbusy && (abusy == addr);

    always_comb begin
        rd   = '0;
        busy = 1'b0;
        if (in_range && !is_zero) begin
            if (hit4)
                rd = wd4;
            else if (hit3)
                rd = wd3;
            else
                rd = stored;
            // An in-flight long-latency result retires the pending bit early, unless reissued.
            busy = stored_busy && !(hit4 && !reissue);
        end
    end

endmodule

// File: rtl/regfile_scb.sv
// Multi-port register file with two write ports and a per-register busy scoreboard.
module regfile_scb
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned NREAD    = DEF_NREAD,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = addr_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREAD*AW-1:0]    a,
    output logic [NREAD*WIDTH-1:0] rd,
    output logic [NREAD-1:0]       busy,
    output logic [DEPTH-1:0]       busy_vec,
    input  logic                   we3,
    input  logic [AW-1:0]          a3,
    input  logic [WIDTH-1:0]       wd3,
    input  logic                   we4,
    input  logic [AW-1:0]          a4,
    input  logic [WIDTH-1:0]       wd4,
    input  logic                   setbusy,
    input  logic [AW-1:0]          abusy
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy_q;

    function automatic logic wr_ok(input logic [AW-1:0] addr);
        return (32'(addr) < DEPTH) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    // Port 4 is written last so it wins an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            if (we3 && wr_ok(a3))
                regs[a3] <= wd3;
            if (we4 && wr_ok(a4))
                regs[a4] <= wd4;
        end
    end

    // Set follows clear so a same-cycle reissue keeps the register pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            if (we4 && wr_ok(a4))
                busy_q[a4] <= 1'b0;
            if (setbusy && wr_ok(abusy))
                busy_q[abusy] <= 1'b1;
        end
    end

    assign busy_vec = busy_q;

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] stored;
        logic             stored_busy;

        assign addr        = a[i*AW +: AW];
        assign stored      = (32'(addr) < DEPTH) ? regs[addr] : '0;
        assign stored_busy = (32'(addr) < DEPTH) ? busy_q[addr] : 1'b0;

        regfile_rdport #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .addr        (addr),
            .stored      (stored),
            .stored_busy (stored_busy),
            .we3         (we3),
            .a3          (a3),
            .wd3         (wd3),
            .we4         (we4),
            .a4          (a4),
            .wd4         (wd4),
            .setbusy     (setbusy),
            .abusy       (abusy),
            .rd          (rd[i*WIDTH +: WIDTH]),
            .busy        (busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_scb.sv
// Scoreboard-driven bench for regfile_scb: bypass, no-bypass and non-power-of-two depth instances.
module tb_regfile_scb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  a = '0;
    logic        we3 = 1'b0, we4 = 1'b0, setbusy = 1'b0;
    logic [4:0]  a3 = '0, a4 = '0, abusy = '0;
    logic [31:0] wd3 = '0, wd4 = '0;

    logic [63:0] rd, rd_nb, rd_rg;
    logic [1:0]  busy, busy_nb, busy_rg;
    logic [31:0] busy_vec, busy_vec_nb;
    logic [19:0] busy_vec_rg;

    logic [63:0] exp_q [$];
    logic [63:0] e;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_scb #(.WIDTH(32), .DEPTH(32), .NREAD(2), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .a(a), .rd(rd), .busy(busy), .busy_vec(busy_vec),
        .we3(we3), .a3(a3), .wd3(wd3), .we4(we4), .a4(a4), .wd4(wd4),
        .setbusy(setbusy), .abusy(abusy));

    regfile_scb #(.WIDTH(32), .DEPTH(32), .NREAD(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .reset(reset), .a(a), .rd(rd_nb), .busy(busy_nb), .busy_vec(busy_vec_nb),
        .we3(we3), .a3(a3), .wd3(wd3), .we4(we4), .a4(a4), .wd4(wd4),
        .setbusy(setbusy), .abusy(abusy));

    regfile_scb #(.WIDTH(32), .DEPTH(20), .NREAD(2), .BYPASS(1), .ZERO_REG(1)) dut_rg (
        .clk(clk), .reset(reset), .a(a), .rd(rd_rg), .busy(busy_rg), .busy_vec(busy_vec_rg),
        .we3(we3), .a3(a3), .wd3(wd3), .we4(we4), .a4(a4), .wd4(wd4),
        .setbusy(setbusy), .abusy(abusy));

    task automatic idle();
        we3 = 1'b0; we4 = 1'b0; setbusy = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        we3 = 1'b1; a3 = 5'd1; wd3 = 32'hFFFF_FFFF; a = {5'd2, 5'd2};
        exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        repeat (2) @(posedge clk);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (busy_vec !== e[31:0]) begin n_err++; $display("FAIL reset_busy_vec_held: got %h want %h", busy_vec, e[31:0]); end
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e) begin n_err++; $display("FAIL reset_rd_held: got %h want %h", rd, e); end
        reset = 1'b0; idle(); a = {5'd1, 5'd1};
        exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e) begin n_err++; $display("FAIL reset_rd_reg1: got %h want %h", rd, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (busy !== e[1:0]) begin n_err++; $display("FAIL reset_busy: got %b want %b", busy, e[1:0]); end
        e = exp_q.pop_front(); n_cmp++;
        if (busy_vec !== e[31:0]) begin n_err++; $display("FAIL reset_busy_vec: got %h want %h", busy_vec, e[31:0]); end
        e = exp_q.pop_front(); n_cmp++;
        if ({rd_nb, busy_vec_nb} !== {e, 32'h0}) begin n_err++; $display("FAIL reset_nobypass: got %h/%h want %h/0", rd_nb, busy_vec_nb, e); end
        step();
    endtask

    task automatic test_basic();
        we3 = 1'b1; a3 = 5'd1; wd3 = 32'hABCD_EFAB; a = {5'd0, 5'd1};
        exp_q.push_back(64'hABCD_EFAB); exp_q.push_back(64'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd[31:0] !== e[31:0]) begin n_err++; $display("FAIL basic_bypass: got %h want %h", rd[31:0], e[31:0]); end
        e = exp_q.pop_front(); n_cmp++;
        if (rd_nb[31:0] !== e[31:0]) begin n_err++; $display("FAIL basic_nobypass_before: got %h want %h", rd_nb[31:0], e[31:0]); end
        exp_q.push_back(64'hABCD_EFAB); exp_q.push_back(64'hABCD_EFAB);
        step(); idle(); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd[31:0] !== e[31:0]) begin n_err++; $display("FAIL basic_after: got %h want %h", rd[31:0], e[31:0]); end
        e = exp_q.pop_front(); n_cmp++;
        if (rd_nb[31:0] !== e[31:0]) begin n_err++; $display("FAIL basic_nobypass_after: got %h want %h", rd_nb[31:0], e[31:0]); end
        step();
    endtask

    task automatic test_zero_reg();
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'hCCCC_CCCC; a = {5'd0, 5'd0};
        exp_q.push_back(64'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e) begin n_err++; $display("FAIL zero_bypass: got %h want %h", rd, e); end
        step(); idle(); setbusy = 1'b1; abusy = 5'd0;
        exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e) begin n_err++; $display("FAIL zero_stored: got %h want %h", rd, e); end
        step(); idle(); #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({busy_vec, 2'b00, busy} !== {e[31:0], 4'h0}) begin n_err++; $display("FAIL zero_setbusy: got %h/%b want %h/0", busy_vec, busy, e[31:0]); end
        step();
    endtask

    task automatic test_collision();
        we3 = 1'b1; a3 = 5'd2; wd3 = 32'h0123_4567;
        we4 = 1'b1; a4 = 5'd2; wd4 = 32'h3333_4567; a = {5'd2, 5'd2};
        exp_q.push_back(64'h3333_4567_3333_4567); exp_q.push_back(64'h3333_4567);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e) begin n_err++; $display("FAIL collision_bypass: got %h want %h", rd, e); end
        step(); idle(); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd_nb[31:0] !== e[31:0]) begin n_err++; $display("FAIL collision_stored: got %h want %h", rd_nb[31:0], e[31:0]); end
        step();
    endtask

    task automatic test_scoreboard();
        setbusy = 1'b1; abusy = 5'd5; a = {5'd1, 5'd5};
        exp_q.push_back(64'h0); exp_q.push_back(64'h0000_0020); exp_q.push_back(64'h1);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (busy_vec !== e[31:0]) begin n_err++; $display("FAIL sb_set_latency: got %h want %h", busy_vec, e[31:0]); end
        step(); idle(); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (busy_vec !== e[31:0]) begin n_err++; $display("FAIL sb_set: got %h want %h", busy_vec, e[31:0]); end
        e = exp_q.pop_front(); n_cmp++;
        if (busy !== e[1:0]) begin n_err++; $display("FAIL sb_set_port: got %b want %b", busy, e[1:0]); end
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEAD_0005;
        exp_q.push_back(64'h0000_0020); exp_q.push_back(64'hDEAD_0005);
        step(); idle(); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (busy_vec !== e[31:0]) begin n_err++; $display("FAIL sb_we3_keeps: got %h want %h", busy_vec, e[31:0]); end
        e = exp_q.pop_front(); n_cmp++;
        if (rd[31:0] !== e[31:0]) begin n_err++; $display("FAIL sb_we3_data: got %h want %h", rd[31:0], e[31:0]); end
        we4 = 1'b1; a4 = 5'd5; wd4 = 32'h1234_5678;
        exp_q.push_back(64'h0); exp_q.push_back(64'h1); exp_q.push_back(64'h0000_0020);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (busy !== e[1:0]) begin n_err++; $display("FAIL sb_we4_bypass_busy: got %b want %b", busy, e[1:0]); end
        e = exp_q.pop_front(); n_cmp++;
        if (busy_nb !== e[1:0]) begin n_err++; $display("FAIL sb_we4_nobypass_busy: got %b want %b", busy_nb, e[1:0]); end
        e = exp_q.pop_front(); n_cmp++;
        if (busy_vec !== e[31:0]) begin n_err++; $display("FAIL sb_vec_no_bypass: got %h want %h", busy_vec, e[31:0]); end
        exp_q.push_back(64'h0); exp_q.push_back(64'h1234_5678);
        step(); idle(); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (busy_vec !== e[31:0]) begin n_err++; $display("FAIL sb_clear: got %h want %h", busy_vec, e[31:0]); end
        e = exp_q.pop_front(); n_cmp++;
        if (rd[31:0] !== e[31:0]) begin n_err++; $display("FAIL sb_clear_data: got %h want %h", rd[31:0], e[31:0]); end
        setbusy = 1'b1; abusy = 5'd5;
        step();
        we4 = 1'b1; a4 = 5'd5; wd4 = 32'h0000_0055;
        exp_q.push_back(64'h1); exp_q.push_back(64'h0000_0020); exp_q.push_back(64'h0000_0055);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (busy !== e[1:0]) begin n_err++; $display("FAIL sb_reissue_port: got %b want %b", busy, e[1:0]); end
        step(); idle(); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (busy_vec !== e[31:0]) begin n_err++; $display("FAIL sb_reissue_vec: got %h want %h", busy_vec, e[31:0]); end
        e = exp_q.pop_front(); n_cmp++;
        if (rd[31:0] !== e[31:0]) begin n_err++; $display("FAIL sb_reissue_data: got %h want %h", rd[31:0], e[31:0]); end
        we4 = 1'b1; a4 = 5'd5; wd4 = 32'h0000_0055;
        step(); idle();
    endtask

    task automatic test_range();
        we3 = 1'b1; a3 = 5'd25; wd3 = 32'h7777_7777;
        we4 = 1'b1; a4 = 5'd19; wd4 = 32'h1919_1919;
        setbusy = 1'b1; abusy = 5'd25; a = {5'd19, 5'd25};
        exp_q.push_back(64'h1919_1919_0000_0000); exp_q.push_back(64'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd_rg !== e) begin n_err++; $display("FAIL range_bypass: got %h want %h", rd_rg, e); end
        step(); idle(); #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({busy_vec_rg, busy_rg} !== e[21:0]) begin n_err++; $display("FAIL range_busy: got %h/%b want 0", busy_vec_rg, busy_rg); end
        exp_q.push_back(64'h1919_1919_0000_0000); exp_q.push_back(64'h0200_0000);
        e = exp_q.pop_front(); n_cmp++;
        if (rd_rg !== e) begin n_err++; $display("FAIL range_stored: got %h want %h", rd_rg, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (busy_vec !== e[31:0]) begin n_err++; $display("FAIL range_full_depth_busy: got %h want %h", busy_vec, e[31:0]); end
        we4 = 1'b1; a4 = 5'd25; wd4 = '0;
        step(); idle();
    endtask

    task automatic test_mid_reset();
        we3 = 1'b1; a3 = 5'd1; wd3 = 32'h1111_1111;
        we4 = 1'b1; a4 = 5'd2; wd4 = 32'h2222_2222;
        step(); idle();
        we3 = 1'b1; a3 = 5'd3; wd3 = 32'h3333_3333; setbusy = 1'b1; abusy = 5'd5;
        step(); idle(); a = {5'd3, 5'd1};
        exp_q.push_back(64'h3333_3333_1111_1111); exp_q.push_back(64'h0000_0020);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e) begin n_err++; $display("FAIL mid_before: got %h want %h", rd, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (busy_vec !== e[31:0]) begin n_err++; $display("FAIL mid_before_busy: got %h want %h", busy_vec, e[31:0]); end
        #1 reset = 1'b1;
        exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e) begin n_err++; $display("FAIL mid_async_rd: got %h want %h", rd, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (busy_vec !== e[31:0]) begin n_err++; $display("FAIL mid_async_busy: got %h want %h", busy_vec, e[31:0]); end
        step(); reset = 1'b0;
        we3 = 1'b1; a3 = 5'd1; wd3 = 32'h0000_0009; a = {5'd2, 5'd1};
        exp_q.push_back(64'h0); exp_q.push_back(64'h0000_0009);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd_nb !== e) begin n_err++; $display("FAIL post_reset_before: got %h want %h", rd_nb, e); end
        step(); idle(); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd_nb !== e) begin n_err++; $display("FAIL post_reset_first_write: got %h want %h", rd_nb, e); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_reg();
        test_collision();
        test_scoreboard();
        test_range();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_scb.md
# regfile_scb

Parametrised multi-port register file with a per-register busy scoreboard, the next-generation replacement for the fixed 32x32 two-read/one-write register file in the multicycle datapath. It provides a configurable number of combinational read ports and two clocked write ports: a primary ALU/writeback port (3) and a long-latency unit port (4). Optional same-cycle write-to-read bypass and a hardwired zero register are supported. The scoreboard tracks registers awaiting a long-latency result, so control can stall on RAW hazards.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers (>= 2, need not be a power of two)
- NREAD, 2, number of read ports (1..8)
- BYPASS, 1, 1 = reads return same-cycle write data
- ZERO_REG, 1, 1 = register 0 reads 0; writes and busy-sets to it are ignored
- AW (localparam), $clog2(DEPTH), address width
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all registers and busy bits
- a  in  NREAD*AW  read addresses; port i at [i*AW +: AW]
- rd  out  NREAD*WIDTH  read data; port i at [i*WIDTH +: WIDTH]
- busy  out  NREAD  scoreboard status of each read address
- busy_vec  out  DEPTH  full scoreboard, bit r = register r pending
- we3, a3, wd3  in  1, AW, WIDTH  primary write port
- we4, a4, wd4  in  1, AW, WIDTH  long-latency write port; also clears busy
- setbusy, abusy  in  1, AW  mark register abusy pending

## Operation
- Storage: DEPTH x WIDTH flops plus DEPTH busy flops, all 0 during and after reset.
- Read (combinational), per port i:
  - If ZERO_REG and a_i == 0, rd_i = 0.
  - Else if a_i >= DEPTH, rd_i = 0.
  - Else if BYPASS and we4 and a4 == a_i, rd_i = wd4.
  - Else if BYPASS and we3 and a3 == a_i, rd_i = wd3.
  - Else rd_i = reg[a_i].
- Write: on the rising edge, if we3, reg[a3] <= wd3. If we4, reg[a4] <= wd4.
  - Port 4 wins on an address collision.
  - Writes to an address >= DEPTH are ignored, as are writes to register 0 when ZERO_REG.
- Scoreboard, per register r on the rising edge:
  - Set when setbusy and abusy == r.
  - Cleared when we4 and a4 == r.
  - Set and clear in the same cycle on the same r: set wins, so busy stays 1 (reissue).
  - we3 never clears busy.
  - setbusy to register 0 (when ZERO_REG) or to an address >= DEPTH is ignored.
- busy_i = busy_vec[a_i], 0 for out-of-range addresses and for register 0 when ZERO_REG.
  - With BYPASS, busy_i is also forced to 0 when we4 and a4 == a_i, unless setbusy and abusy == a_i in the same cycle.
- busy_vec is taken directly from the flops and has no bypass.

## Timing
- Read latency 0: rd and busy are combinational from a, the register state and, when BYPASS=1, the write-port inputs.
- Write latency 1: data is visible through the flops after the next rising edge.
- Scoreboard update latency 1 cycle; busy_vec changes only at rising edges or on reset.
- reset asserts asynchronously. While it is high:
  - all outputs derived from state are 0, except bypassed read data;
  - writes and setbusy are ignored.
- An edge coinciding with reset assertion performs no write.
- The first write takes effect on the first rising edge after reset deasserts.

## Structure
- Package regfile_pkg: default WIDTH/DEPTH/NREAD constants and a function computing AW.
- Sub-module regfile_rdport: one read port's zero/range/bypass mux plus busy qualification, instantiated NREAD times in a generate loop.
- The top level holds the storage, write logic and scoreboard flops.

## Test plan
- **Reset:** hold reset 2 cycles with we3=1, a3=1, wd3=0xFFFFFFFF → no write. After release, all rd = 0, busy = 0, busy_vec = 0.
- **Basic write/read:** we3, a3=1, wd3=0xABCDEFAB.
  - With BYPASS=1, a0=1 shows 0xABCDEFAB in the same cycle.
  - With BYPASS=0, a0=1 shows 0 until the next edge, then 0xABCDEFAB.
- **Zero register:** we3, a3=0, wd3=0xCCCCCCCC, then a0=0 → rd0 = 0. setbusy with abusy=0 → busy_vec[0] stays 0.
- **Write collision:** we3, a3=2, wd3=0x01234567 and we4, a4=2, wd4=0x33334567 in the same cycle → register 2 reads 0x33334567 afterwards.
- **Scoreboard:**
  - setbusy, abusy=5 → busy_vec[5] = 1 next cycle.
  - we3 to register 5 → busy stays 1.
  - we4 to register 5 with wd4=0x12345678 → busy clears and rd = 0x12345678.
  - setbusy and we4 on register 5 in the same cycle → busy remains 1.
- **Mid-operation reset:** with registers 1..3 written and register 5 busy, assert reset between edges → all rd and busy_vec go to 0 immediately, without waiting for a clock edge.
